// File: rtl/gray_to_binary_arbiter.sv
// Purpose: round-robin share of one Gray-to-binary converter among NUM_REQ requesters.
// Latency: 1 cycle from acceptance to Rsp_Valid_Out; one result per cycle when drained.
// Backpressure: while the result is held and Rsp_Ready_In is low, no requester is granted.
//
// Ports:
//   Clock_In, Reset_n_In       clock and asynchronous active-low reset
//   Enable_In                  gates new grants; a held result still drains
//   Req_Valid_In/Req_Data_In   per-requester valid and Gray word (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   Req_Ready_Out              one-hot grant, combinational
//   Rsp_Valid_Out/Rsp_Ready_In output register handshake
//   Rsp_Data_Out/Rsp_Id_Out    binary result and originating requester index
module gray_to_binary_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 32,
   localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          Clock_In,
   input  logic                          Reset_n_In,
   input  logic                          Enable_In,
   input  logic [NUM_REQ-1:0]            Req_Valid_In,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
   output logic [NUM_REQ-1:0]            Req_Ready_Out,
   output logic                          Rsp_Valid_Out,
   input  logic                          Rsp_Ready_In,
   output logic [DATA_WIDTH-1:0]         Rsp_Data_Out,
   output logic [ID_WIDTH-1:0]           Rsp_Id_Out
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q;
   logic                  can_accept;
   logic                  grant_vld;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic [DATA_WIDTH-1:0] gray_sel;
   logic [DATA_WIDTH-1:0] bin_sel;

   // The output slot frees up in the same cycle the consumer takes the
   // current result, so a new grant can overlap the drain with no bubble.
   always_comb begin
      can_accept = Enable_In & ((state_q == EMPTY) | Rsp_Ready_In);
   end

   // Round-robin search starting at the pointer and wrapping at NUM_REQ.
   always_comb begin
      int                  cand_int;
      logic [ID_WIDTH-1:0] cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_int  = 0;
      cand      = '0;
      if (can_accept) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand_int = int'(rr_ptr_q) + k;
            if (cand_int >= NUM_REQ) begin
               cand_int = cand_int - NUM_REQ;
            end
            cand = ID_WIDTH'(cand_int);
            if (!grant_vld && Req_Valid_In[cand]) begin
               grant_vld = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   // Ready is held low for the whole time reset is asserted, not just
   // from the next edge, so no requester sees a phantom acceptance.
   always_comb begin
      Req_Ready_Out = '0;
      if (Reset_n_In && grant_vld) begin
         Req_Ready_Out[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      gray_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_WIDTH'(i)) begin
            gray_sel = Req_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Binary bit k is the XOR of all Gray bits from the MSB down to k.
   // Written as a reduction of the shifted word to keep the logic acyclic.
   always_comb begin
      bin_sel = '0;
      for (int k = 0; k < DATA_WIDTH; k++) begin
         bin_sel[k] = ^(gray_sel >> k);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (grant_vld) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (Rsp_Ready_In && !grant_vld) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         Rsp_Data_Out <= '0;
         Rsp_Id_Out   <= '0;
         rr_ptr_q     <= '0;
      end else if (grant_vld) begin
         Rsp_Data_Out <= bin_sel;
         Rsp_Id_Out   <= grant_idx;
         rr_ptr_q     <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign Rsp_Valid_Out = (state_q == FULL);

endmodule

// File: tb/tb_gray_to_binary_arbiter.sv
module tb_gray_to_binary_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 32;
   localparam int ID_WIDTH   = 2;

   logic                          clk;
   logic                          rst_n;
   logic                          en;
   logic [NUM_REQ-1:0]            req_vld;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_dat;
   logic [NUM_REQ-1:0]            req_rdy;
   logic                          rsp_vld;
   logic                          rsp_rdy;
   logic [DATA_WIDTH-1:0]         rsp_dat;
   logic [ID_WIDTH-1:0]           rsp_id;

   int checks;
   int errors;

   gray_to_binary_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .Clock_In      (clk),
      .Reset_n_In    (rst_n),
      .Enable_In     (en),
      .Req_Valid_In  (req_vld),
      .Req_Data_In   (req_dat),
      .Req_Ready_Out (req_rdy),
      .Rsp_Valid_Out (rsp_vld),
      .Rsp_Ready_In  (rsp_rdy),
      .Rsp_Data_Out  (rsp_dat),
      .Rsp_Id_Out    (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_vld = '0;
      rst_n   = 1'b0;
      step();
      step();
      rst_n   = 1'b1;
   endtask

   // Gray 0..3 for the round-robin test and their binary equivalents.
   logic [31:0] rr_bin [4];

   initial begin
      checks  = 0;
      errors  = 0;
      rr_bin[0] = 32'h0;
      rr_bin[1] = 32'h1;
      rr_bin[2] = 32'h3;
      rr_bin[3] = 32'h2;

      rst_n   = 1'b0;
      en      = 1'b0;
      rsp_rdy = 1'b0;
      req_vld = 4'hF;
      req_dat = '0;
      #3;
      // Ready must be low during reset even with everyone valid and enabled.
      en = 1'b1;
      rsp_rdy = 1'b1;
      #1;
      check("reset_rdy", 64'(req_rdy), 64'h0);
      check("reset_vld", 64'(rsp_vld), 64'h0);
      check("reset_dat", 64'(rsp_dat), 64'h0);
      check("reset_id",  64'(rsp_id),  64'h0);
      step();
      check("reset_rdy_edge", 64'(req_rdy), 64'h0);
      req_vld = '0;
      rst_n   = 1'b1;

      // Single request: requester 2, Gray 6 -> binary 4.
      req_dat[2*32 +: 32] = 32'h0000_0006;
      req_vld = 4'b0100;
      #1;
      check("single_rdy", 64'(req_rdy), 64'h4);
      step();
      req_vld = '0;
      check("single_vld", 64'(rsp_vld), 64'h1);
      check("single_dat", 64'(rsp_dat), 64'h4);
      check("single_id",  64'(rsp_id),  64'h2);
      step();
      check("single_drain", 64'(rsp_vld), 64'h0);

      // Round-robin from pointer 0 with wrap.
      do_reset();
      for (int i = 0; i < 4; i++) req_dat[i*32 +: 32] = 32'(i);
      req_vld = 4'hF;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("rr_rdy%0d", k), 64'(req_rdy), 64'(4'b0001 << (k % 4)));
         step();
         check($sformatf("rr_vld%0d", k), 64'(rsp_vld), 64'h1);
         check($sformatf("rr_id%0d", k),  64'(rsp_id),  64'(k % 4));
         check($sformatf("rr_dat%0d", k), 64'(rsp_dat), 64'(rr_bin[k % 4]));
      end
      req_vld = '0;
      step();
      check("rr_drain", 64'(rsp_vld), 64'h0);

      // Backpressure: hold Id 1 / 0xFFFFFFFF while requester 3 waits.
      do_reset();
      req_dat[1*32 +: 32] = 32'h8000_0000;
      req_dat[3*32 +: 32] = 32'h0000_000F;
      req_vld = 4'b0010;
      step();
      req_vld = 4'b1000;
      rsp_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_rdy%0d", k), 64'(req_rdy), 64'h0);
         check($sformatf("bp_vld%0d", k), 64'(rsp_vld), 64'h1);
         check($sformatf("bp_dat%0d", k), 64'(rsp_dat), 64'hFFFF_FFFF);
         check($sformatf("bp_id%0d", k),  64'(rsp_id),  64'h1);
         step();
      end
      rsp_rdy = 1'b1;
      #1;
      check("bp_release_rdy", 64'(req_rdy), 64'h8);
      step();
      req_vld = '0;
      check("bp_reload_vld", 64'(rsp_vld), 64'h1);
      check("bp_reload_dat", 64'(rsp_dat), 64'hA);
      check("bp_reload_id",  64'(rsp_id),  64'h3);

      // Conversion values through requester 0, back to back.
      req_vld = 4'b0001;
      req_dat[0 +: 32] = 32'hC000_0000;
      step();
      check("conv_c0", 64'(rsp_dat), 64'h8000_0000);
      req_dat[0 +: 32] = 32'h0000_0003;
      step();
      check("conv_03", 64'(rsp_dat), 64'h0000_0002);
      req_dat[0 +: 32] = 32'h0000_0000;
      step();
      check("conv_00", 64'(rsp_dat), 64'h0000_0000);
      check("conv_id", 64'(rsp_id),  64'h0);

      // Enable gating: pointer is now 1, result from requester 0 held.
      en = 1'b0;
      req_vld = 4'b0011;
      req_dat[1*32 +: 32] = 32'h8000_0000;
      #1;
      check("en_rdy0", 64'(req_rdy), 64'h0);
      check("en_held", 64'(rsp_vld), 64'h1);
      step();
      check("en_drained", 64'(rsp_vld), 64'h0);
      check("en_rdy1", 64'(req_rdy), 64'h0);
      step();
      check("en_still_empty", 64'(rsp_vld), 64'h0);
      en = 1'b1;
      #1;
      check("en_resume_rdy", 64'(req_rdy), 64'h2);
      step();
      check("en_resume_id",  64'(rsp_id),  64'h1);
      check("en_resume_dat", 64'(rsp_dat), 64'hFFFF_FFFF);

      // Reset mid-operation while FULL with requesters valid.
      rsp_rdy = 1'b0;
      req_vld = 4'b0101;
      req_dat[0 +: 32]    = 32'h0000_0006;
      req_dat[2*32 +: 32] = 32'h0000_0003;
      step();
      check("mid_full", 64'(rsp_vld), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", 64'(rsp_vld), 64'h0);
      check("mid_rst_dat", 64'(rsp_dat), 64'h0);
      check("mid_rst_id",  64'(rsp_id),  64'h0);
      check("mid_rst_rdy", 64'(req_rdy), 64'h0);
      step();
      #2;
      rst_n   = 1'b1;
      rsp_rdy = 1'b1;
      #1;
      check("post_rst_rdy", 64'(req_rdy), 64'h1);
      step();
      req_vld = '0;
      check("post_rst_id",  64'(rsp_id),  64'h0);
      check("post_rst_dat", 64'(rsp_dat), 64'h4);
      check("post_rst_vld", 64'(rsp_vld), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
